// File: rtl/coin_vend_pkg.sv
// Shared types and constants for the coin vending controller.
//   state_t      : controller phase (ACCUM, VEND, CHANGE)
//   NICKEL/DIME/QUARTER : coin values in cents
package coin_vend_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [4:0] NICKEL  = 5'd5;
  localparam logic [4:0] DIME    = 5'd10;
  localparam logic [4:0] QUARTER = 5'd25;

endpackage

// File: rtl/coin_decode.sv
// Combinational coin-sensor decoder.
//   n, d, q : nickel / dime / quarter sensed this cycle
//   any     : at least one sensor high
//   valid   : exactly one sensor high (value is meaningful)
//   multi   : more than one sensor high (ambiguous, must be rejected)
//   value   : cents of the single sensed coin, 0 otherwise
module coin_decode
  import coin_vend_pkg::*;
(
  input  logic       n,
  input  logic       d,
  input  logic       q,
  output logic       any,
  output logic       valid,
  output logic       multi,
  output logic [4:0] value
);

  logic [1:0] count;

  always_comb begin
    count = {1'b0, n} + {1'b0, d} + {1'b0, q};
    any   = (count != 2'd0);
    valid = (count == 2'd1);
    multi = (count > 2'd1);
    value = 5'd0;
    if (valid) begin
      if (n)      value = NICKEL;
      else if (d) value = DIME;
      else        value = QUARTER;
    end
  end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Vending controller: accumulates coin credit toward PRICE, pulses z once
// per sale, then either pays excess back as dime/nickel pulses or carries
// it into the next sale (CARRY_CHANGE). Cancel refunds the held credit.
//   Clock, Resetn : rising-edge clock, synchronous active-low reset
//   N, D, Q       : coin sensors;  Cancel : refund request
//   z             : vend pulse;  nickel_out / dime_out : change pulses
//   coin_reject   : sampled coin was returned (registered, one cycle)
//   credit        : current credit in cents;  busy : VEND or CHANGE
// Handshake: there is no back-pressure. A coin is offered for exactly the
// cycle its sensor is high; it is accepted only when busy is low and it is
// the sole coin without Cancel, otherwise coin_reject pulses next cycle.
module coin_vend_ctrl
  import coin_vend_pkg::*;
#(
  parameter int unsigned PRICE        = 15,
  parameter int unsigned CREDIT_W     = 7,
  parameter bit          CARRY_CHANGE = 1'b0
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                Cancel,
  output logic                z,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(DIME);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic                coin_any, coin_valid, coin_multi;
  logic [4:0]          coin_value;
  logic [CREDIT_W-1:0] sum, remainder;

  coin_decode u_decode (
    .n     (N),
    .d     (D),
    .q     (Q),
    .any   (coin_any),
    .valid (coin_valid),
    .multi (coin_multi),
    .value (coin_value)
  );

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    reject_d  = 1'b0;
    sum       = credit_q + CREDIT_W'(coin_value);
    remainder = credit_q - PRICE_C;

    case (state_q)
      ACCUM: begin
        if (Cancel) begin
          // A coin arriving with Cancel is always handed back.
          reject_d = coin_any;
          if (credit_q != '0) state_d = CHANGE;
        end else if (coin_multi) begin
          reject_d = 1'b1;
        end else if (coin_valid) begin
          credit_d = sum;
          if (sum >= PRICE_C) state_d = VEND;
        end
      end
      VEND: begin
        reject_d = coin_any;
        credit_d = remainder;
        if (remainder == '0 || CARRY_CHANGE) state_d = ACCUM;
        else                                  state_d = CHANGE;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q >= DIME_C)        credit_d = credit_q - DIME_C;
        else if (credit_q >= NICKEL_C) credit_d = credit_q - NICKEL_C;
        else                           credit_d = '0;
        if (credit_d == '0) state_d = ACCUM;
      end
      default: begin
        state_d  = ACCUM;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= ACCUM;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Outputs are pure decodes of the registers; the change coin for this
  // cycle is chosen from the credit still owed.
  assign z           = (state_q == VEND);
  assign busy        = (state_q != ACCUM);
  assign dime_out    = (state_q == CHANGE) && (credit_q >= DIME_C);
  assign nickel_out  = (state_q == CHANGE) && (credit_q < DIME_C) && (credit_q >= NICKEL_C);
  assign coin_reject = reject_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
module tb_coin_vend_ctrl;

  localparam int CW = 7;
  localparam int NI = 3;
  // entry = {kind[1:0], credit[6:0]}; kind 1=vend, 2=dime, 3=nickel
  localparam int EW = CW + 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn, n_i, d_i, q_i, c_i;
  logic          z_o [NI];
  logic          nk_o[NI];
  logic          dm_o[NI];
  logic          rj_o[NI];
  logic          bz_o[NI];
  logic [CW-1:0] cr_o[NI];

  coin_vend_ctrl #(.PRICE(15), .CREDIT_W(CW), .CARRY_CHANGE(1'b0)) u_p15_chg (
    .Clock(clk), .Resetn(rn), .N(n_i), .D(d_i), .Q(q_i), .Cancel(c_i),
    .z(z_o[0]), .nickel_out(nk_o[0]), .dime_out(dm_o[0]),
    .coin_reject(rj_o[0]), .credit(cr_o[0]), .busy(bz_o[0]));

  coin_vend_ctrl #(.PRICE(15), .CREDIT_W(CW), .CARRY_CHANGE(1'b1)) u_p15_carry (
    .Clock(clk), .Resetn(rn), .N(n_i), .D(d_i), .Q(q_i), .Cancel(c_i),
    .z(z_o[1]), .nickel_out(nk_o[1]), .dime_out(dm_o[1]),
    .coin_reject(rj_o[1]), .credit(cr_o[1]), .busy(bz_o[1]));

  coin_vend_ctrl #(.PRICE(5), .CREDIT_W(CW), .CARRY_CHANGE(1'b0)) u_p5_chg (
    .Clock(clk), .Resetn(rn), .N(n_i), .D(d_i), .Q(q_i), .Cancel(c_i),
    .z(z_o[2]), .nickel_out(nk_o[2]), .dime_out(dm_o[2]),
    .coin_reject(rj_o[2]), .credit(cr_o[2]), .busy(bz_o[2]));

  // ---------------- reference model ----------------
  // Each sale is planned up front as a list of output cycles (vend, then
  // change coins) in exp_q; while the list is non-empty the unit is busy.
  int         price_m[NI] = '{15, 15, 5};
  bit         carry_m[NI] = '{1'b0, 1'b1, 1'b0};
  logic [EW-1:0] exp_q[NI][$];
  int         mcred[NI];
  bit         mrej[NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_ev(input int i, input int kind, input int cents);
    logic [EW-1:0] e;
    e = {2'(kind), CW'(cents)};
    exp_q[i].push_back(e);
  endtask

  task automatic plan_change(input int i, input int amt);
    int a;
    a = amt;
    while (a > 0) begin
      if (a >= 10) begin push_ev(i, 2, a); a -= 10; end
      else         begin push_ev(i, 3, a); a -= 5;  end
    end
  endtask

  task automatic model_step(input bit r, input bit n, input bit d, input bit q, input bit c);
    int ncoin, v;
    ncoin = int'(n) + int'(d) + int'(q);
    for (int i = 0; i < NI; i++) begin
      if (!r) begin
        exp_q[i].delete();
        mcred[i] = 0;
        mrej[i]  = 1'b0;
      end else if (exp_q[i].size() > 0) begin
        mrej[i] = (ncoin != 0);
        void'(exp_q[i].pop_front());
      end else begin
        mrej[i] = 1'b0;
        if (c) begin
          mrej[i] = (ncoin != 0);
          if (mcred[i] > 0) begin
            plan_change(i, mcred[i]);
            mcred[i] = 0;
          end
        end else if (ncoin > 1) begin
          mrej[i] = 1'b1;
        end else if (ncoin == 1) begin
          v = n ? 5 : (d ? 10 : 25);
          mcred[i] += v;
          if (mcred[i] >= price_m[i]) begin
            push_ev(i, 1, mcred[i]);
            if (carry_m[i]) mcred[i] = mcred[i] - price_m[i];
            else begin
              plan_change(i, mcred[i] - price_m[i]);
              mcred[i] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [EW-1:0] e;
    int kind, ecred;
    for (int i = 0; i < NI; i++) begin
      kind = 0;
      ecred = mcred[i];
      if (exp_q[i].size() > 0) begin
        e = exp_q[i][0];
        kind = int'(e[EW-1:CW]);
        ecred = int'(e[CW-1:0]);
      end
      check($sformatf("z[%0d]", i),      32'(z_o[i]),  32'(kind == 1));
      check($sformatf("dime[%0d]", i),   32'(dm_o[i]), 32'(kind == 2));
      check($sformatf("nickel[%0d]", i), 32'(nk_o[i]), 32'(kind == 3));
      check($sformatf("busy[%0d]", i),   32'(bz_o[i]), 32'(exp_q[i].size() > 0));
      check($sformatf("reject[%0d]", i), 32'(rj_o[i]), 32'(mrej[i]));
      check($sformatf("credit[%0d]", i), 32'(cr_o[i]), 32'(ecred));
      check($sformatf("excl[%0d]", i),
            32'((dm_o[i] & nk_o[i]) | ((dm_o[i] | nk_o[i]) & z_o[i])), 32'(0));
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input bit r, input bit n, input bit d, input bit q, input bit c);
    rn = r; n_i = n; d_i = d; q_i = q; c_i = c;
    @(posedge clk);
    model_step(r, n, d, q, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) apply(1, 0, 0, 0, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int r, sel;
    for (int i = 0; i < NI; i++) begin mcred[i] = 0; mrej[i] = 1'b0; end
    rn = 1'b0; n_i = 1'b0; d_i = 1'b0; q_i = 1'b0; c_i = 1'b0;

    // reset with coins held high, then release
    apply(0, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0);
    idle(2);

    // nickel then dime: exact price on the 15c units
    apply(1, 1, 0, 0, 0);
    apply(1, 0, 1, 0, 0);
    idle(4);

    // quarter: change on one unit, carried credit on another
    apply(1, 0, 0, 1, 0);
    idle(4);
    apply(1, 1, 0, 0, 0);
    idle(4);

    // dime then Cancel together with a nickel: refund
    apply(1, 0, 1, 0, 0);
    apply(1, 1, 0, 0, 1);
    idle(4);

    // two coins at once in ACCUM, then cancel
    apply(1, 1, 0, 0, 0);
    apply(1, 1, 1, 0, 0);
    idle(1);
    apply(1, 0, 0, 0, 1);
    idle(4);

    // quarter, then coins during VEND/CHANGE are rejected
    apply(1, 0, 0, 1, 0);
    apply(1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    idle(4);

    // reset in the middle of change payout
    apply(1, 0, 0, 1, 0);
    idle(1);
    apply(0, 0, 0, 0, 0);
    idle(4);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      r = (($urandom_range(0, 199)) != 0) ? 1 : 0;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2, 3, 4: apply(r[0], 0, 0, 0, $urandom_range(0, 9) == 0);
        5, 6:          apply(r[0], 1, 0, 0, $urandom_range(0, 9) == 0);
        7, 8:          apply(r[0], 0, 1, 0, $urandom_range(0, 9) == 0);
        9, 10:         apply(r[0], 0, 0, 1, $urandom_range(0, 9) == 0);
        default:       apply(r[0], $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, 0);
      endcase
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
